exec_issue_ctrl: RTL and testbench

EXEC_ISSUE_CTRL -- requirements
Module: exec_issue_ctrl

---
 rtl/exec_issue_ctrl_pkg.sv | 15 +
 rtl/exec_issue_ctrl_flag_hazard_tracker.sv | 45 ++++
 rtl/exec_issue_ctrl.sv | 90 +++++++++
 tb/tb_exec_issue_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/exec_issue_ctrl_pkg.sv
// Shared CPU issue-control types: ctrl_state codes and flag latency default.
package exec_issue_ctrl_pkg;

    localparam int unsigned FLAG_LAT_DEF = 2;
    localparam int unsigned PEND_W       = 3;
    localparam int unsigned STALL_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HAZ  = 2'd2,
        ST_HOLD = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/exec_issue_ctrl_flag_hazard_tracker.sv
// Tracks in-flight flag writes; EXEC_ISSUE_CTRL_FLAG_FWD_EN swaps the
// conditional stall for a forward-select of the youngest writer's flags.
module flag_hazard_tracker
    import exec_issue_ctrl_pkg::*;
#(
    parameter int unsigned FLAG_LAT = FLAG_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_dec_valid,
    input  logic       i_dec_is_cond,
    input  logic [3:0] i_dec_write_flags,
    input  logic       i_ex_en,
    output logic       o_hazard,
    output logic       o_flag_fwd_sel
);

    localparam logic [PEND_W-1:0] LAT = PEND_W'(FLAG_LAT);

    logic [PEND_W-1:0] r_pend;
    logic              w_wr_issue;

    assign w_wr_issue = i_ex_en && (i_dec_write_flags != 4'd0);

    // Flush does not touch this: issued flag writes always complete.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend <= '0;
        end else if (w_wr_issue) begin
            r_pend <= LAT;
        end else if (r_pend != '0) begin
            r_pend <= r_pend - 1'b1;
        end
    end

`ifdef EXEC_ISSUE_CTRL_FLAG_FWD_EN
    assign o_hazard       = 1'b0;
    assign o_flag_fwd_sel = i_ex_en && i_dec_valid && i_dec_is_cond
                            && (r_pend == LAT);
`else
    assign o_hazard       = i_dec_valid && i_dec_is_cond && (r_pend != '0);
    assign o_flag_fwd_sel = 1'b0;
`endif

endmodule

// File: rtl/exec_issue_ctrl.sv
// Execute-stage issue controller: flag hazards, mem backpressure, flush.
// Optional flag forwarding: define EXEC_ISSUE_CTRL_FLAG_FWD_EN.
module exec_issue_ctrl
    import exec_issue_ctrl_pkg::*;
#(
    parameter int unsigned FLAG_LAT = FLAG_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  logic               dec_is_cond,
    input  logic [3:0]         dec_write_flags,
    input  logic               flush,
    input  logic               mem_ready,
    output logic               ex_en,
    output logic               ex_valid,
    output logic               flag_fwd_sel,
    output logic [1:0]         ctrl_state,
    output logic [STALL_W-1:0] stall_cnt
);

    logic               w_hazard;
    logic               w_down_ok;
    logic               w_fwd_sel;
    logic               r_ex_valid;
    logic [STALL_W-1:0] r_stall_cnt;
    ctrl_state_e        w_state;

    assign w_down_ok = !r_ex_valid || mem_ready;
    assign dec_ready = rst && w_down_ok && !w_hazard && !flush;
    assign ex_en     = dec_valid && dec_ready;

    flag_hazard_tracker #(
        .FLAG_LAT (FLAG_LAT)
    ) u_tracker (
        .clk               (clk),
        .rst               (rst),
        .i_dec_valid       (dec_valid),
        .i_dec_is_cond     (dec_is_cond),
        .i_dec_write_flags (dec_write_flags),
        .i_ex_en           (ex_en),
        .o_hazard          (w_hazard),
        .o_flag_fwd_sel    (w_fwd_sel)
    );

    assign flag_fwd_sel = w_fwd_sel;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ex_valid <= 1'b0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (ex_en) begin
            r_ex_valid <= 1'b1;
        end else if (mem_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (dec_valid && !dec_ready && !flush
                     && (r_stall_cnt != {STALL_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // State reflects the conditions seen by the upcoming issue edge.
    always_comb begin
        w_state = ST_IDLE;
        if (!rst) begin
            w_state = ST_IDLE;
        end else if (flush) begin
            w_state = ST_IDLE;
        end else if (r_ex_valid && !mem_ready) begin
            w_state = ST_HOLD;
        end else if (w_hazard) begin
            w_state = ST_HAZ;
        end else if (dec_valid || r_ex_valid) begin
            w_state = ST_RUN;
        end
    end

    assign ctrl_state = w_state;
    assign ex_valid   = r_ex_valid;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Scoreboard bench for exec_issue_ctrl at default FLAG_LAT=2.
module tb_exec_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic        dec_ready;
    logic        dec_is_cond;
    logic [3:0]  dec_write_flags;
    logic        flush;
    logic        mem_ready;
    logic        ex_en;
    logic        ex_valid;
    logic        flag_fwd_sel;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    exec_issue_ctrl #(.FLAG_LAT(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_is_cond     (dec_is_cond),
        .dec_write_flags (dec_write_flags),
        .flush           (flush),
        .mem_ready       (mem_ready),
        .ex_en           (ex_en),
        .ex_valid        (ex_valid),
        .flag_fwd_sel    (flag_fwd_sel),
        .ctrl_state      (ctrl_state),
        .stall_cnt       (stall_cnt)
    );

    localparam logic [1:0] I  = 2'd0;
    localparam logic [1:0] R  = 2'd1;
    localparam logic [1:0] H  = 2'd2;
    localparam logic [1:0] HD = 2'd3;
    localparam logic [3:0] F  = 4'hF;

    typedef struct {
        string       tag;
        logic        dr;
        logic        ee;
        logic        ev;
        logic        fs;
        logic [1:0]  st;
        bit          sk;
        logic [15:0] sc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_stall = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle and queue what the outputs must show during it.
    task automatic cyc(input string tag, input logic r, input logic dv,
                       input logic cnd, input logic [3:0] wf,
                       input logic fl, input logic mr,
                       input logic er, input logic ee, input logic ev,
                       input logic [1:0] st, input logic fs, input bit sk);
        exp_t e;
        rst             = r;
        dec_valid       = dv;
        dec_is_cond     = cnd;
        dec_write_flags = wf;
        flush           = fl;
        mem_ready       = mr;
        e.tag = tag;
        e.dr  = er;
        e.ee  = ee;
        e.ev  = ev;
        e.fs  = fs;
        e.st  = st;
        e.sk  = sk;
        e.sc  = exp_stall;
        sb.push_back(e);
        if (!r) exp_stall = 16'd0;
        else if (dv && !er && !fl && exp_stall != 16'hFFFF)
            exp_stall = exp_stall + 16'd1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, ".dec_ready"}, dec_ready, e.dr);
            chk({e.tag, ".ex_en"}, ex_en, e.ee);
            chk({e.tag, ".ex_valid"}, ex_valid, e.ev);
            chk({e.tag, ".fwd_sel"}, flag_fwd_sel, e.fs);
            chk({e.tag, ".stall_cnt"}, stall_cnt, e.sc);
            if (!e.sk) chk({e.tag, ".state"}, ctrl_state, e.st);
        end
    end

    initial begin
        rst             = 1'b0;
        dec_valid       = 1'b0;
        dec_is_cond     = 1'b0;
        dec_write_flags = 4'h0;
        flush           = 1'b0;
        mem_ready       = 1'b1;
        @(posedge clk);
        #1;
        // reset holds everything quiet even with decode offering
        cyc("rst0", 0, 1, 0, 0, 0, 1, 0, 0, 0, I, 0, 0);
        cyc("rst1", 0, 1, 1, F, 0, 1, 0, 0, 0, I, 0, 0);
        cyc("idle", 1, 0, 0, 0, 0, 1, 1, 0, 0, I, 0, 0);
        // flag writer then conditional, back to back
        cyc("a0", 1, 1, 0, F, 0, 1, 1, 1, 0, R, 0, 0);
`ifdef EXEC_ISSUE_CTRL_FLAG_FWD_EN
        cyc("a1", 1, 1, 1, 0, 0, 1, 1, 1, 1, R, 1, 0);
        cyc("a2", 1, 0, 0, 0, 0, 1, 1, 0, 1, R, 0, 0);
        cyc("a3", 1, 0, 0, 0, 0, 1, 1, 0, 0, I, 0, 0);
`else
        cyc("a1", 1, 1, 1, 0, 0, 1, 0, 0, 1, H, 0, 0);
        cyc("a2", 1, 1, 1, 0, 0, 1, 0, 0, 0, H, 0, 0);
        cyc("a3", 1, 1, 1, 0, 0, 1, 1, 1, 0, R, 0, 0);
        cyc("a4", 1, 0, 0, 0, 0, 1, 1, 0, 1, R, 0, 0);
`endif
        // memory backpressure for three cycles
        cyc("b0", 1, 1, 0, 0, 0, 1, 1, 1, 0, R, 0, 0);
        cyc("b1", 1, 1, 0, 0, 0, 0, 0, 0, 1, HD, 0, 0);
        cyc("b2", 1, 1, 0, 0, 0, 0, 0, 0, 1, HD, 0, 0);
        cyc("b3", 1, 1, 0, 0, 0, 0, 0, 0, 1, HD, 0, 0);
        cyc("b4", 1, 1, 0, 0, 0, 1, 1, 1, 1, R, 0, 0);
        cyc("b5", 1, 0, 0, 0, 0, 1, 1, 0, 1, R, 0, 0);
        cyc("b6", 1, 0, 0, 0, 0, 1, 1, 0, 0, I, 0, 0);
        // hazard and backpressure together; mem clears last
        cyc("c0", 1, 1, 0, F, 0, 1, 1, 1, 0, R, 0, 0);
        cyc("c1", 1, 1, 1, 0, 0, 0, 0, 0, 1, HD, 0, 0);
        cyc("c2", 1, 1, 1, 0, 0, 0, 0, 0, 1, HD, 0, 0);
        cyc("c3", 1, 1, 1, 0, 0, 0, 0, 0, 1, HD, 0, 0);
        cyc("c4", 1, 1, 1, 0, 0, 1, 1, 1, 1, R, 0, 0);
        cyc("c5", 1, 0, 0, 0, 0, 1, 1, 0, 1, R, 0, 0);
        cyc("c6", 1, 0, 0, 0, 0, 1, 1, 0, 0, I, 0, 0);
        // flush while the conditional waits; execute is killed
        cyc("d0", 1, 1, 0, F, 0, 1, 1, 1, 0, R, 0, 0);
        cyc("d1", 1, 1, 1, 0, 1, 0, 0, 0, 1, I, 0, 0);
        cyc("d2", 1, 0, 0, 0, 0, 0, 1, 0, 0, I, 0, 0);
        cyc("d3", 1, 1, 1, 0, 0, 1, 1, 1, 0, R, 0, 0);
        cyc("d4", 1, 0, 0, 0, 0, 1, 1, 0, 1, R, 0, 0);
        cyc("d5", 1, 0, 0, 0, 0, 1, 1, 0, 0, I, 0, 0);
        // non-conditional writer issues while pending and reloads
        cyc("e0", 1, 1, 0, F, 0, 1, 1, 1, 0, R, 0, 0);
        cyc("e1", 1, 1, 0, F, 0, 1, 1, 1, 1, R, 0, 0);
`ifdef EXEC_ISSUE_CTRL_FLAG_FWD_EN
        cyc("e2", 1, 1, 1, 0, 0, 1, 1, 1, 1, R, 1, 0);
        cyc("e3", 1, 0, 0, 0, 0, 1, 1, 0, 1, R, 0, 0);
        cyc("e4", 1, 0, 0, 0, 0, 1, 1, 0, 0, I, 0, 0);
`else
        cyc("e2", 1, 1, 1, 0, 0, 1, 0, 0, 1, H, 0, 0);
        cyc("e3", 1, 1, 1, 0, 0, 1, 0, 0, 0, H, 0, 0);
        cyc("e4", 1, 1, 1, 0, 0, 1, 1, 1, 0, R, 0, 0);
        cyc("e5", 1, 0, 0, 0, 0, 1, 1, 0, 1, R, 0, 0);
        cyc("e6", 1, 0, 0, 0, 0, 1, 1, 0, 0, I, 0, 0);
`endif
        // reset while the writer sits blocked in execute
        cyc("f0", 1, 1, 0, F, 0, 1, 1, 1, 0, R, 0, 0);
        cyc("f1", 0, 1, 1, 0, 0, 0, 0, 0, 1, I, 0, 1);
        cyc("f2", 1, 1, 1, 0, 0, 1, 1, 1, 0, R, 0, 0);
        // permanent stall saturates the counter
        cyc("g0", 1, 1, 0, 0, 0, 1, 1, 1, 1, R, 0, 0);
        mem_ready = 1'b0;
        repeat (65534) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("sat_minus1", stall_cnt, 32'hFFFE);
        @(posedge clk);
        #1;
        repeat (4465) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("sat_hold", stall_cnt, 32'hFFFF);
        chk("sat_state", ctrl_state, HD);
        chk("sat_ready", dec_ready, 1'b0);
        @(posedge clk);
        #1;
        dec_valid = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
